// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcode constants, the NOP instruction word
// used as the decode register's idle value, and the immediate-format enum with
// the helpers that classify an opcode.
package decode_pkg;

   localparam logic [31:0] NOP_IR_DEFAULT = 32'h00000013;  // addi x0,x0,0

   localparam logic [6:0] OP_LOAD     = 7'h03;
   localparam logic [6:0] OP_MISC_MEM = 7'h0F;
   localparam logic [6:0] OP_IMM      = 7'h13;
   localparam logic [6:0] OP_AUIPC    = 7'h17;
   localparam logic [6:0] OP_STORE    = 7'h23;
   localparam logic [6:0] OP_REG      = 7'h33;
   localparam logic [6:0] OP_LUI      = 7'h37;
   localparam logic [6:0] OP_BRANCH   = 7'h63;
   localparam logic [6:0] OP_JALR     = 7'h67;
   localparam logic [6:0] OP_JAL      = 7'h6F;
   localparam logic [6:0] OP_SYSTEM   = 7'h73;

   typedef enum logic [2:0] {
      FMT_NONE,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J
   } imm_fmt_e;

   // Immediate layout carried by each opcode; anything else has no immediate.
   function automatic imm_fmt_e imm_fmt_of(input logic [6:0] op);
      imm_fmt_e fmt;
      case (op)
         OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: fmt = FMT_I;
         OP_STORE:                            fmt = FMT_S;
         OP_BRANCH:                           fmt = FMT_B;
         OP_LUI, OP_AUIPC:                    fmt = FMT_U;
         OP_JAL:                              fmt = FMT_J;
         default:                             fmt = FMT_NONE;
      endcase
      return fmt;
   endfunction

   // True for the base-ISA major opcodes; the two low bits must be 2'b11,
   // which every listed opcode already carries.
   function automatic logic is_rv32i(input logic [6:0] op);
      logic ok;
      case (op)
         OP_LOAD, OP_MISC_MEM, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
         OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: ok = 1'b1;
         default:                                       ok = 1'b0;
      endcase
      return ok && (op[1:0] == 2'b11);
   endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational RV32I immediate generator: picks the immediate layout from the
// opcode and sign-extends from IR[31]; opcodes without an immediate give 0.
module decode_imm_gen
   import decode_pkg::*;
(
   input  logic [31:0] ir,
   output logic [31:0] imm
);

   logic signed [31:0] imm_s;

   // Reassemble the scattered immediate fields for the instruction's format.
   always_comb begin
      imm_s = '0;
      case (imm_fmt_of(ir[6:0]))
         FMT_I:   imm_s = {{20{ir[31]}}, ir[31:20]};
         FMT_S:   imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         FMT_B:   imm_s = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         FMT_U:   imm_s = {ir[31:12], 12'b0};
         FMT_J:   imm_s = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         default: imm_s = '0;
      endcase
   end

   assign imm = imm_s;

endmodule

// File: rtl/decode.sv
// Decode stage: one registered instruction slot between fetch and execute with
// a valid/ready handshake, flush and stall, plus field/immediate/legality
// decode taken from the registered instruction only.
// Build option: define DECODE_SKID_BUF_EN for a two-entry skid buffer with a
// registered r_out; otherwise a single entry whose r_out depends on r_in.
module decode
   import decode_pkg::*;
#(
   parameter logic [31:0] NOP_IR = NOP_IR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PC_in,
   input  logic [31:0] IR_in,
   input  logic        v_in,
   output logic        r_out,
   input  logic        flush,
   input  logic        stall,
   input  logic        r_in,
   output logic        v_out,
   output logic [31:0] PC_out,
   output logic [31:0] IR_out,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [6:0]  opcode,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic [31:0] imm,
   output logic        illegal
);

   logic        vld_p0;
   logic [31:0] pc_p0;
   logic [31:0] ir_p0;
   logic        vld_p0_nxt;
   logic [31:0] pc_p0_nxt;
   logic [31:0] ir_p0_nxt;
   logic        in_xfer;
   logic        out_xfer;

   // stall hides the held entry and blocks input, so neither side transfers
   assign v_out    = vld_p0 && !stall;
   assign in_xfer  = v_in && r_out;
   assign out_xfer = v_out && r_in;

`ifdef DECODE_SKID_BUF_EN
   logic        vld_sk;
   logic [31:0] pc_sk;
   logic [31:0] ir_sk;
   logic        vld_sk_nxt;
   logic [31:0] pc_sk_nxt;
   logic [31:0] ir_sk_nxt;
   logic        rdy_q;

   // upstream sees a registered ready: room exists whenever the skid is empty
   assign r_out = rdy_q && !stall;

   // Next main/skid contents: flush empties both, the skid refills main as
   // soon as main drains, and input overflows into the skid when blocked.
   always_comb begin
      vld_p0_nxt = vld_p0;
      pc_p0_nxt  = pc_p0;
      ir_p0_nxt  = ir_p0;
      vld_sk_nxt = vld_sk;
      pc_sk_nxt  = pc_sk;
      ir_sk_nxt  = ir_sk;
      if (flush) begin
         vld_p0_nxt = 1'b0;
         ir_p0_nxt  = NOP_IR;
         vld_sk_nxt = 1'b0;
      end else if (!stall) begin
         if (vld_sk) begin
            if (out_xfer) begin
               pc_p0_nxt  = pc_sk;
               ir_p0_nxt  = ir_sk;
               vld_sk_nxt = 1'b0;
            end
         end else if (in_xfer) begin
            if (!vld_p0 || out_xfer) begin
               vld_p0_nxt = 1'b1;
               pc_p0_nxt  = PC_in;
               ir_p0_nxt  = IR_in;
            end else begin
               vld_sk_nxt = 1'b1;
               pc_sk_nxt  = PC_in;
               ir_sk_nxt  = IR_in;
            end
         end else if (out_xfer) begin
            vld_p0_nxt = 1'b0;
         end
      end
   end

   // ---- stage p0 register: main entry, skid entry and registered ready ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0 <= 1'b0;
         pc_p0  <= '0;
         ir_p0  <= NOP_IR;
         vld_sk <= 1'b0;
         rdy_q  <= 1'b1;
      end else begin
         vld_p0 <= vld_p0_nxt;
         pc_p0  <= pc_p0_nxt;
         ir_p0  <= ir_p0_nxt;
         vld_sk <= vld_sk_nxt;
         rdy_q  <= !vld_sk_nxt;
      end
   end

   // Skid payload needs no reset; it is only read while vld_sk is set.
   always_ff @(posedge clk) begin
      pc_sk <= pc_sk_nxt;
      ir_sk <= ir_sk_nxt;
   end
`else
   // ready when empty, or when the held entry leaves this same edge
   assign r_out = (!vld_p0 || r_in) && !stall;

   // Next single-entry contents: flush invalidates, a load replaces whatever
   // leaves in the same edge, a lone output transfer empties the slot.
   always_comb begin
      vld_p0_nxt = vld_p0;
      pc_p0_nxt  = pc_p0;
      ir_p0_nxt  = ir_p0;
      if (flush) begin
         vld_p0_nxt = 1'b0;
         ir_p0_nxt  = NOP_IR;
      end else if (!stall) begin
         if (in_xfer) begin
            vld_p0_nxt = 1'b1;
            pc_p0_nxt  = PC_in;
            ir_p0_nxt  = IR_in;
         end else if (out_xfer) begin
            vld_p0_nxt = 1'b0;
         end
      end
   end

   // ---- stage p0 register: the single decode entry ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0 <= 1'b0;
         pc_p0  <= '0;
         ir_p0  <= NOP_IR;
      end else begin
         vld_p0 <= vld_p0_nxt;
         pc_p0  <= pc_p0_nxt;
         ir_p0  <= ir_p0_nxt;
      end
   end
`endif

   assign PC_out  = pc_p0;
   assign IR_out  = ir_p0;
   assign rd      = ir_p0[11:7];
   assign rs1     = ir_p0[19:15];
   assign rs2     = ir_p0[24:20];
   assign opcode  = ir_p0[6:0];
   assign funct3  = ir_p0[14:12];
   assign funct7  = ir_p0[31:25];
   assign illegal = !is_rv32i(ir_p0[6:0]);

   decode_imm_gen u_imm_gen (
      .ir  (ir_p0),
      .imm (imm)
   );

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: a table of instructions streamed back to back
// with hand-computed decode results, then short sequences for back-pressure,
// flush, stall and reset.
module tb_decode;
   import decode_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] PC_in;
   logic [31:0] IR_in;
   logic        v_in;
   logic        r_out;
   logic        flush;
   logic        stall;
   logic        r_in;
   logic        v_out;
   logic [31:0] PC_out;
   logic [31:0] IR_out;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm;
   logic        illegal;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] ir;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic        ill;
   } vec_t;

   vec_t        tbl [12];
   logic [31:0] exp_q [$];
   bit          rin_pat [24] = '{1,1,0,0,0,1,1,0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1};

   decode dut (
      .clk     (clk),
      .rst     (rst),
      .PC_in   (PC_in),
      .IR_in   (IR_in),
      .v_in    (v_in),
      .r_out   (r_out),
      .flush   (flush),
      .stall   (stall),
      .r_in    (r_in),
      .v_out   (v_out),
      .PC_out  (PC_out),
      .IR_out  (IR_out),
      .rd      (rd),
      .rs1     (rs1),
      .rs2     (rs2),
      .opcode  (opcode),
      .funct3  (funct3),
      .funct7  (funct7),
      .imm     (imm),
      .illegal (illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int sent;
      int got;
      logic [31:0] w;

      tbl[0]  = '{32'hFFF00093, 32'h10, 5'd1,  5'd0,  5'd31, 32'hFFFFFFFF, 1'b0};
      tbl[1]  = '{32'h0020A423, 32'h14, 5'd8,  5'd1,  5'd2,  32'h00000008, 1'b0};
      tbl[2]  = '{32'hFE000EE3, 32'h18, 5'd29, 5'd0,  5'd0,  32'hFFFFFFFC, 1'b0};
      tbl[3]  = '{32'h123452B7, 32'h1C, 5'd5,  5'd8,  5'd3,  32'h12345000, 1'b0};
      tbl[4]  = '{32'h001000EF, 32'h20, 5'd1,  5'd0,  5'd1,  32'h00000800, 1'b0};
      tbl[5]  = '{32'hFFFFF06F, 32'h24, 5'd0,  5'd31, 5'd31, 32'hFFFFFFFE, 1'b0};
      tbl[6]  = '{32'h0000007F, 32'h28, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b1};
      tbl[7]  = '{32'h00000000, 32'h2C, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b1};
      tbl[8]  = '{32'hFFFFF197, 32'h30, 5'd3,  5'd31, 5'd31, 32'hFFFFF000, 1'b0};
      tbl[9]  = '{32'h002081B3, 32'h34, 5'd3,  5'd1,  5'd2,  32'h00000000, 1'b0};
      tbl[10] = '{32'h0FF0000F, 32'h38, 5'd0,  5'd0,  5'd31, 32'h00000000, 1'b0};
      tbl[11] = '{32'h00000001, 32'h3C, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b1};

      // reset state
      rst = 1'b1; v_in = 1'b0; PC_in = '0; IR_in = '0;
      flush = 1'b0; stall = 1'b0; r_in = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
      chk("rst v_out",   32'(v_out),   32'd0);
      chk("rst PC_out",  PC_out,       32'd0);
      chk("rst IR_out",  IR_out,       32'h00000013);
      chk("rst illegal", 32'(illegal), 32'd0);
      chk("rst r_out",   32'(r_out),   32'd1);

      // table stream, r_in high: one output per cycle, no gaps
      for (int i = 0; i < 12; i++) begin
         v_in  = 1'b1;
         IR_in = tbl[i].ir;
         PC_in = tbl[i].pc;
         step();
         w = tbl[i].ir;
         chk($sformatf("v%0d v_out", i),   32'(v_out),   32'd1);
         chk($sformatf("v%0d PC_out", i),  PC_out,       tbl[i].pc);
         chk($sformatf("v%0d IR_out", i),  IR_out,       tbl[i].ir);
         chk($sformatf("v%0d rd", i),      32'(rd),      32'(tbl[i].rd));
         chk($sformatf("v%0d rs1", i),     32'(rs1),     32'(tbl[i].rs1));
         chk($sformatf("v%0d rs2", i),     32'(rs2),     32'(tbl[i].rs2));
         chk($sformatf("v%0d opcode", i),  32'(opcode),  32'(w[6:0]));
         chk($sformatf("v%0d funct3", i),  32'(funct3),  32'(w[14:12]));
         chk($sformatf("v%0d funct7", i),  32'(funct7),  32'(w[31:25]));
         chk($sformatf("v%0d imm", i),     imm,          tbl[i].imm);
         chk($sformatf("v%0d illegal", i), 32'(illegal), 32'(tbl[i].ill));
         chk($sformatf("v%0d r_out", i),   32'(r_out),   32'd1);
      end
      v_in = 1'b0;
      step();
      chk("drain v_out", 32'(v_out), 32'd0);

      // back-pressure: 8 items, r_in low for 3 cycles, order tracked in a queue
      sent = 0;
      got  = 0;
      for (int c = 0; c < 24; c++) begin
         v_in  = (sent < 8);
         PC_in = 32'h100 + 32'(sent) * 4;
         IR_in = 32'h13 | (32'(sent) << 7);
         r_in  = rin_pat[c];
         #1;
`ifdef DECODE_SKID_BUF_EN
         if (c == 2) chk("bp r_out on r_in fall", 32'(r_out), 32'd1);
         if (c == 3) chk("bp r_out one later",    32'(r_out), 32'd0);
`else
         if (c == 2) chk("bp r_out on r_in fall", 32'(r_out), 32'd0);
         if (c == 3) chk("bp r_out one later",    32'(r_out), 32'd0);
`endif
         if (v_in && r_out) begin
            exp_q.push_back(PC_in);
            sent++;
         end
         if (v_out && r_in) begin
            if (exp_q.size() == 0) begin
               chk("bp spurious output", PC_out, 32'hFFFFFFFF);
            end else begin
               chk($sformatf("bp order %0d", got), PC_out, exp_q.pop_front());
            end
            got++;
         end
         step();
      end
      chk("bp all delivered", 32'(got), 32'd8);
      v_in = 1'b0;
      r_in = 1'b1;
      step();
      chk("bp empty", 32'(v_out), 32'd0);

      // flush while full with a same-cycle input
      v_in = 1'b1; PC_in = 32'h500; IR_in = 32'h00100093; r_in = 1'b0;
      step();
      chk("fl full", 32'(v_out), 32'd1);
      flush = 1'b1; PC_in = 32'h504; IR_in = 32'h00200093;
      step();
      flush = 1'b0; v_in = 1'b0;
      #1;
      chk("fl v_out",  32'(v_out), 32'd0);
      chk("fl IR_out", IR_out,     32'h00000013);
      chk("fl r_out",  32'(r_out), 32'd1);

      // first instruction after flush decodes normally
      v_in = 1'b1; PC_in = 32'h10; IR_in = 32'hFFF00093; r_in = 1'b1;
      step();
      v_in = 1'b0;
      chk("addi v_out",   32'(v_out),   32'd1);
      chk("addi PC_out",  PC_out,       32'h10);
      chk("addi rd",      32'(rd),      32'd1);
      chk("addi rs1",     32'(rs1),     32'd0);
      chk("addi imm",     imm,          32'hFFFFFFFF);
      chk("addi illegal", 32'(illegal), 32'd0);
      step();
      chk("addi gone", 32'(v_out), 32'd0);

      // stall two cycles while full
      v_in = 1'b1; PC_in = 32'h200; IR_in = 32'h00500093; r_in = 1'b0;
      step();
      v_in = 1'b0; stall = 1'b1; r_in = 1'b1;
      #1;
      chk("st v_out c0", 32'(v_out), 32'd0);
      chk("st r_out c0", 32'(r_out), 32'd0);
      step();
      chk("st v_out c1", 32'(v_out), 32'd0);
      chk("st r_out c1", 32'(r_out), 32'd0);
      chk("st PC c1",    PC_out,     32'h200);
      step();
      chk("st PC c2",    PC_out,     32'h200);
      chk("st IR c2",    IR_out,     32'h00500093);
      stall = 1'b0;
      #1;
      chk("st release v_out", 32'(v_out), 32'd1);
      chk("st release PC",    PC_out,     32'h200);
      step();
      chk("st once", 32'(v_out), 32'd0);

      // reset mid-stream drops held and incoming entries
      v_in = 1'b1; PC_in = 32'h300; IR_in = 32'h00600093; r_in = 1'b0;
      step();
      chk("mr full", 32'(v_out), 32'd1);
      rst = 1'b1; PC_in = 32'h304; IR_in = 32'h00700093;
      step();
      rst = 1'b0; v_in = 1'b0;
      #1;
      chk("mr v_out",  32'(v_out), 32'd0);
      chk("mr PC_out", PC_out,     32'd0);
      chk("mr IR_out", IR_out,     32'h00000013);
      chk("mr r_out",  32'(r_out), 32'd1);
      v_in = 1'b1; PC_in = 32'h400; IR_in = 32'h00000073; r_in = 1'b1;
      step();
      v_in = 1'b0;
      chk("mr next PC",      PC_out,       32'h400);
      chk("mr next illegal", 32'(illegal), 32'd0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 Parameter: NOP_IR, 32'h00000013, instruction word held in the output register after reset and flush.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 PC_in  input  32  PC of the incoming instruction, from fetch PC_out.
REQ-005 IR_in  input  32  incoming instruction word, from fetch IR_out.
REQ-006 v_in  input  1  upstream valid, from fetch v_out.
REQ-007 r_out  output  1  ready to upstream, drives fetch r_in.
REQ-008 flush  input  1  taken branch/jump from execute (same signal as fetch COMP_alu).
REQ-009 stall  input  1  hazard stall; hold contents, no transfer either side.
REQ-010 r_in  input  1  downstream ready, from execute.
REQ-011 v_out  output  1  downstream valid.
REQ-012 PC_out, IR_out  output  32 each  registered PC and instruction.
REQ-013 rd, rs1, rs2  output  5 each  IR[11:7], IR[19:15], IR[24:20] of the output entry.
REQ-014 opcode 7, funct3 3, funct7 7  output  IR[6:0], IR[14:12], IR[31:25].
REQ-015 imm  output  32  sign-extended immediate of the output entry.
REQ-016 illegal  output  1  output entry is not a recognised RV32I encoding.

Function
REQ-017 Input transfer occurs in a cycle where v_in && r_out; output transfer occurs where v_out && r_in.
REQ-018 Latency: an entry accepted in cycle N is presented with v_out=1 in cycle N+1 when the block was empty.
REQ-019 Priority per cycle: rst > flush > stall > normal handshake.
REQ-020 flush: all held entries invalidated, any same-cycle input discarded, v_out=0 and IR_out=NOP_IR next cycle, r_out=1 next cycle.
REQ-021 stall: v_out=0 and r_out=0 combinationally; stored entries, including PC_out/IR_out, unchanged; released unchanged when stall drops.
REQ-022 Full and r_in=1 with v_in=1: old entry leaves, new entry loads in the same edge; no bubble, no loss.
REQ-023 Immediate per opcode: I-type (03,13,67,73) IR[31:20]; S (23) {IR[31:25],IR[11:7]}; B (63) {IR[31],IR[7],IR[30:25],IR[11:8],0}; U (37,17) {IR[31:12],12'b0}; J (6F) {IR[31],IR[19:12],IR[20],IR[30:21],0}; all sign-extended from IR[31]; other opcodes imm=0.
REQ-024 illegal=1 when IR[1:0]!=2'b11 or opcode not in {03,0F,13,17,23,33,37,63,67,6F,73}; entry is still passed with v_out=1.
REQ-025 Decoded outputs are registered or derived combinationally from IR_out only; never from IR_in.

Reset
REQ-026 On rst: v_out=0, all entries empty, PC_out=0, IR_out=NOP_IR, illegal=0; r_out=1 in the first cycle after rst deasserts.
REQ-027 rst asserted mid-transfer discards both the held and the incoming entry.

Configuration
REQ-028 DECODE_SKID_BUF_EN defined: two-entry skid buffer (main plus skid); r_out is a register equal to "skid empty"; the skid entry captures input when r_in drops while full.
REQ-029 DECODE_SKID_BUF_EN undefined: single entry; r_out = !full || r_in (combinational path from r_in); identical transfer order and values.
REQ-030 Both builds produce identical output sequences for identical stimulus, apart from the r_out timing.

Structure
REQ-031 Shared package holds RV32I opcode constants, NOP_IR default, and immediate-format enum.
REQ-032 One sub-module, imm_gen (IR in, imm out, combinational), instantiated once on IR_out.

Verification
REQ-033 IR_in=32'hFFF00093 (addi x1,x0,-1), PC_in=0x10 -> next cycle v_out=1, rd=1, rs1=0, imm=32'hFFFFFFFF, illegal=0.
REQ-034 Back-to-back 8 instructions, r_in=1 always -> 8 outputs on 8 consecutive cycles, in order, no gaps.
REQ-035 r_in=0 for 3 cycles while v_in=1 -> no entry lost or duplicated; skid build drops r_out one cycle after r_in falls.
REQ-036 flush while full and v_in=1 -> next cycle v_out=0, IR_out=32'h00000013; following input decoded normally.
REQ-037 stall for 2 cycles while full -> v_out=0, r_out=0, PC_out unchanged; on release the same entry transfers once.
REQ-038 IR_in=32'h0000007F and IR_in=32'h00000000 -> illegal=1 on each, v_out=1; rst mid-stream -> v_out=0 next cycle.
